// File: rtl/udp_pkg.sv
// Shared UDP transmit definitions: arbiter state encoding, length limits and
// the descriptor payload handed to the UDP engine.
package udp_pkg;

    localparam int unsigned WD_W = 20;

    localparam logic [15:0] MIN_DATA_NUM   = 16'd18;
    localparam logic [15:0] UDP_MAX_BYTES  = 16'd1472;
    localparam logic [7:0]  ETH_IFG_CYCLES = 8'd12;

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_START = 4'b0010,
        S_BUSY  = 4'b0100,
        S_GAP   = 4'b1000
    } arb_state_t;

    typedef struct packed {
        logic [15:0] byte_num;
        logic [31:0] des_ip;
        logic [47:0] des_mac;
    } tx_desc_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NCH = 2,
    parameter int unsigned PW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [PW-1:0]  ptr,
    output logic           valid,
    output logic [PW-1:0]  pick
);

    // Walk from farthest to nearest so the nearest requester is the last write.
    always_comb begin
        valid = 1'b0;
        pick  = '0;
        for (int unsigned i = NCH; i > 0; i--) begin
            if (req[(32'(ptr) + i) % NCH]) begin
                valid = 1'b1;
                pick  = PW'((32'(ptr) + i) % NCH);
            end
        end
    end

endmodule

// File: rtl/udp_tx_arb.sv
// Round-robin scheduler sharing one UDP transmit engine between NCH channels,
// with length checking, inter-packet gap and a start-to-done watchdog.
module udp_tx_arb
    import udp_pkg::*;
#(
    parameter int unsigned     NCH         = 2,
    parameter logic [15:0]     MAX_BYTES   = UDP_MAX_BYTES,
    parameter logic [7:0]      IFG_CYCLES  = ETH_IFG_CYCLES,
    parameter logic [WD_W-1:0] TIMEOUT_CYC = 20'd100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    ch_req,
    input  logic [16*NCH-1:0] ch_byte_num,
    input  logic [32*NCH-1:0] ch_des_ip,
    input  logic [48*NCH-1:0] ch_des_mac,
    input  logic [8*NCH-1:0]  ch_tx_data,
    output logic [NCH-1:0]    ch_gnt,
    output logic [NCH-1:0]    ch_tx_req,
    output logic [NCH-1:0]    ch_done,
    output logic [NCH-1:0]    ch_err,
    output logic              tx_start_en,
    output logic [15:0]       tx_byte_num,
    output logic [31:0]       des_ip,
    output logic [47:0]       des_mac,
    output logic [7:0]        eng_tx_data,
    input  logic              eng_tx_req,
    input  logic              eng_tx_done,
    output logic              busy
);

    localparam int unsigned PW = $clog2(NCH);

    arb_state_t      state, state_nxt;
    logic [PW-1:0]   rr_ptr, rr_nxt, arb_pick;
    logic            arb_valid;
    logic [NCH-1:0]  gnt_nxt, done_nxt, err_nxt;
    logic            start_nxt, busy_nxt;
    tx_desc_t        desc, desc_nxt;
    logic [WD_W-1:0] wd, wd_nxt;
    logic [7:0]      gap_cnt, gap_nxt;
    logic [15:0]     pick_len;

    rr_arbiter #(.NCH(NCH), .PW(PW)) u_rr (
        .req   (ch_req),
        .ptr   (rr_ptr),
        .valid (arb_valid),
        .pick  (arb_pick)
    );

    assign pick_len    = ch_byte_num[16*32'(arb_pick) +: 16];
    assign tx_byte_num = desc.byte_num;
    assign des_ip      = desc.des_ip;
    assign des_mac     = desc.des_mac;

    // Engine data path follows the held grant combinationally.
    assign ch_tx_req = {NCH{eng_tx_req}} & ch_gnt;

    always_comb begin
        eng_tx_data = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            eng_tx_data |= ch_tx_data[8*i +: 8] & {8{ch_gnt[i]}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            rr_ptr      <= PW'(NCH - 1);
            ch_gnt      <= '0;
            ch_done     <= '0;
            ch_err      <= '0;
            tx_start_en <= 1'b0;
            busy        <= 1'b0;
            desc        <= '0;
            wd          <= '0;
            gap_cnt     <= '0;
        end else begin
            state       <= state_nxt;
            rr_ptr      <= rr_nxt;
            ch_gnt      <= gnt_nxt;
            ch_done     <= done_nxt;
            ch_err      <= err_nxt;
            tx_start_en <= start_nxt;
            busy        <= busy_nxt;
            desc        <= desc_nxt;
            wd          <= wd_nxt;
            gap_cnt     <= gap_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        gnt_nxt   = ch_gnt;
        done_nxt  = '0;
        err_nxt   = '0;
        start_nxt = 1'b0;
        desc_nxt  = desc;
        wd_nxt    = wd;
        gap_nxt   = gap_cnt;

        unique case (state)
            S_IDLE: begin
                if (arb_valid) begin
                    rr_nxt = arb_pick;
                    if (pick_len == 16'd0 || pick_len > MAX_BYTES) begin
                        err_nxt[arb_pick] = 1'b1;
                    end else begin
                        desc_nxt.byte_num = pick_len;
                        desc_nxt.des_ip   = ch_des_ip[32*32'(arb_pick) +: 32];
                        desc_nxt.des_mac  = ch_des_mac[48*32'(arb_pick) +: 48];
                        gnt_nxt           = NCH'(1) << arb_pick;
                        state_nxt         = S_START;
                    end
                end
            end
            S_START: begin
                start_nxt = 1'b1;
                wd_nxt    = '0;
                state_nxt = S_BUSY;
            end
            S_BUSY: begin
                // A done on the timeout cycle still counts as a completed packet.
                if (eng_tx_done) begin
                    done_nxt  = ch_gnt;
                    gnt_nxt   = '0;
                    gap_nxt   = '0;
                    state_nxt = S_GAP;
                end else if (wd == TIMEOUT_CYC - WD_W'(1)) begin
                    err_nxt   = ch_gnt;
                    gnt_nxt   = '0;
                    gap_nxt   = '0;
                    state_nxt = S_GAP;
                end else if (wd != '1) begin
                    wd_nxt = wd + WD_W'(1);
                end
            end
            S_GAP: begin
                if (9'(gap_cnt) + 9'd1 >= 9'(IFG_CYCLES)) begin
                    state_nxt = S_IDLE;
                end else begin
                    gap_nxt = gap_cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                gnt_nxt   = '0;
            end
        endcase

        busy_nxt = (state_nxt != S_IDLE);
    end

endmodule

// File: tb/tb_udp_tx_arb.sv
// Randomized bench for udp_tx_arb against a timestamp-based transaction model.
module tb_udp_tx_arb;

    localparam int unsigned NCH  = 2;
    localparam int          MAXB = 1472;
    localparam int          IFG  = 12;
    localparam int          TO   = 300;
    localparam int          NCYC = 9000;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    ch_req;
    logic [16*NCH-1:0] ch_byte_num;
    logic [32*NCH-1:0] ch_des_ip;
    logic [48*NCH-1:0] ch_des_mac;
    logic [8*NCH-1:0]  ch_tx_data;
    logic [NCH-1:0]    ch_gnt, ch_tx_req, ch_done, ch_err;
    logic              tx_start_en;
    logic [15:0]       tx_byte_num;
    logic [31:0]       des_ip;
    logic [47:0]       des_mac;
    logic [7:0]        eng_tx_data;
    logic              eng_tx_req, eng_tx_done, busy;

    udp_tx_arb #(
        .NCH         (NCH),
        .MAX_BYTES   (16'(MAXB)),
        .IFG_CYCLES  (8'(IFG)),
        .TIMEOUT_CYC (20'(TO))
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ch_req      (ch_req),
        .ch_byte_num (ch_byte_num),
        .ch_des_ip   (ch_des_ip),
        .ch_des_mac  (ch_des_mac),
        .ch_tx_data  (ch_tx_data),
        .ch_gnt      (ch_gnt),
        .ch_tx_req   (ch_tx_req),
        .ch_done     (ch_done),
        .ch_err      (ch_err),
        .tx_start_en (tx_start_en),
        .tx_byte_num (tx_byte_num),
        .des_ip      (des_ip),
        .des_mac     (des_mac),
        .eng_tx_data (eng_tx_data),
        .eng_tx_req  (eng_tx_req),
        .eng_tx_done (eng_tx_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;

    // Channel-side stimulus
    logic [15:0] c_len [NCH];
    logic [31:0] c_ip  [NCH];
    logic [47:0] c_mac [NCH];
    bit          did_mid;

    // Reference model: packet timeline expressed as edge numbers
    int             m_grant, m_start, m_free_at, m_last, eng_done_at;
    logic [NCH-1:0] e_gnt, e_done, e_err;
    logic           e_start, e_busy;
    logic [15:0]    e_len;
    logic [31:0]    e_ip;
    logic [47:0]    e_mac;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [15:0] gen_len();
        int unsigned r;
        r = $urandom % 10;
        case (r)
            0:       return 16'd0;
            1:       return 16'(1473 + $urandom % 600);
            2:       return 16'(MAXB);
            3:       return 16'd1;
            default: return 16'(1 + $urandom % MAXB);
        endcase
    endfunction

    task automatic end_pkt(input int e);
        m_grant     = -1;
        m_free_at   = e + IFG + 1;
        eng_done_at = -1;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step(input int e);
        int  p;
        bit  found;
        int unsigned r;
        e_done  = '0;
        e_err   = '0;
        e_start = 1'b0;
        if (rst) begin
            m_grant     = -1;
            m_last      = NCH - 1;
            m_free_at   = e + 1;
            eng_done_at = -1;
            e_len       = '0;
            e_ip        = '0;
            e_mac       = '0;
        end else if (m_grant >= 0) begin
            if (e == m_start) begin
                e_start = 1'b1;
            end else if (eng_tx_done) begin
                e_done[m_grant] = 1'b1;
                end_pkt(e);
            end else if (e == m_start + TO) begin
                e_err[m_grant] = 1'b1;
                end_pkt(e);
            end
        end else if (e >= m_free_at && ch_req != '0) begin
            found = 1'b0;
            p     = m_last;
            for (int k = 1; k <= int'(NCH); k++) begin
                if (!found && ch_req[(m_last + k) % NCH]) begin
                    found = 1'b1;
                    p     = (m_last + k) % NCH;
                end
            end
            m_last = p;
            if (c_len[p] == 16'd0 || int'(c_len[p]) > MAXB) begin
                e_err[p] = 1'b1;
            end else begin
                m_grant = p;
                m_start = e + 1;
                e_len   = c_len[p];
                e_ip    = c_ip[p];
                e_mac   = c_mac[p];
                r = $urandom % 16;
                if (r == 0)      eng_done_at = -1;
                else if (r == 1) eng_done_at = m_start + TO;
                else             eng_done_at = m_start + 1 + int'($urandom % 80);
            end
        end
        e_gnt  = (m_grant >= 0) ? NCH'(1) << m_grant : '0;
        e_busy = (m_grant >= 0) || (e + 1 < m_free_at);
    endtask

    task automatic pack_inputs();
        for (int i = 0; i < int'(NCH); i++) begin
            ch_byte_num[16*i +: 16] = c_len[i];
            ch_des_ip[32*i +: 32]   = c_ip[i];
            ch_des_mac[48*i +: 48]  = c_mac[i];
        end
    endtask

    // Drive inputs that the DUT will sample at edge e+1.
    task automatic drive_next(input int e);
        for (int i = 0; i < int'(NCH); i++) begin
            if ((e_done[i] || e_err[i]) && ($urandom % 4 != 0)) begin
                ch_req[i] = 1'b0;
            end else if (!ch_req[i] && ($urandom % 12 == 0)) begin
                ch_req[i] = 1'b1;
                c_len[i]  = gen_len();
                c_ip[i]   = $urandom;
                c_mac[i]  = {16'($urandom), 32'($urandom)};
            end
        end
        pack_inputs();
        rst = (e + 1 < 3);
        if (!did_mid && e > 3000 && m_grant >= 0 && e == m_start + 4) begin
            rst     = 1'b1;
            did_mid = 1'b1;
        end
        eng_tx_done = (eng_done_at == e + 1) || (m_grant < 0 && ($urandom % 24 == 0));
        eng_tx_req  = 1'($urandom % 2);
        ch_tx_data  = NCH*8'($urandom);
    endtask

    initial begin
        logic [7:0] exp_data;
        rst         = 1'b1;
        ch_req      = '0;
        eng_tx_done = 1'b0;
        eng_tx_req  = 1'b0;
        ch_tx_data  = '0;
        did_mid     = 1'b0;
        for (int i = 0; i < int'(NCH); i++) begin
            c_len[i] = '0;
            c_ip[i]  = '0;
            c_mac[i] = '0;
        end
        pack_inputs();
        m_grant     = -1;
        m_start     = 0;
        m_free_at   = 0;
        m_last      = NCH - 1;
        eng_done_at = -1;

        for (cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            model_step(cyc);
            #1;
            check("gnt",   64'(ch_gnt),      64'(e_gnt));
            check("start", 64'(tx_start_en), 64'(e_start));
            check("done",  64'(ch_done),     64'(e_done));
            check("err",   64'(ch_err),      64'(e_err));
            check("busy",  64'(busy),        64'(e_busy));
            check("len",   64'(tx_byte_num), 64'(e_len));
            check("ip",    64'(des_ip),      64'(e_ip));
            check("mac",   64'(des_mac),     64'(e_mac));
            drive_next(cyc);
            #1;
            exp_data = (m_grant >= 0) ? ch_tx_data[8*m_grant +: 8] : 8'd0;
            check("txreq",  64'(ch_tx_req),   64'({NCH{eng_tx_req}} & e_gnt));
            check("txdata", 64'(eng_tx_data), 64'(exp_data));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
